// File: rtl/regs_writeback_pkg.sv
// Shared widths and the writeback entry type for the register-file write port.
package regs_writeback_pkg;

  localparam int REG_IDX_W = 5;
  localparam int XLEN      = 32;
  localparam int NUM_REGS  = 1 << REG_IDX_W;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      data;
  } wb_entry_t;

  // One-hot destination vector used to build the pending-destination mask.
  function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_IDX_W-1:0] rd);
    logic [NUM_REGS-1:0] v;
    v     = '0;
    v[rd] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/regs_writeback_wb_fifo.sv
// Slow-result buffer: strict-order synchronous FIFO with wrap-bit pointers and
// a per-slot valid/rd view so the parent can build its pending-destination mask.
module wb_fifo
  import regs_writeback_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  logic [REG_IDX_W-1:0]         i_push_rd,
  input  logic [XLEN-1:0]              i_push_data,
  input  logic                         i_pop,
  output logic [REG_IDX_W-1:0]         o_head_rd,
  output logic [XLEN-1:0]              o_head_data,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [DEPTH-1:0]             o_entry_valid,
  output logic [DEPTH*REG_IDX_W-1:0]   o_entry_rd
);

  localparam int AW = $clog2(DEPTH);

  wb_entry_t       r_mem [DEPTH];
  logic [AW:0]     r_wr_ptr;
  logic [AW:0]     r_rd_ptr;
  logic [AW:0]     w_count;
  logic            w_do_push;
  logic            w_do_pop;

  // Equal low bits: the wrap bit tells empty (same lap) from full (one lap apart).
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                   (r_wr_ptr[AW] != r_rd_ptr[AW]);

  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign w_count   = r_wr_ptr - r_rd_ptr;

  assign o_head_rd   = r_mem[r_rd_ptr[AW-1:0]].rd;
  assign o_head_data = r_mem[r_rd_ptr[AW-1:0]].data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]].rd   <= i_push_rd;
      r_mem[r_wr_ptr[AW-1:0]].data <= i_push_data;
    end
  end

  // A slot is live when its distance from the read pointer is below occupancy.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_view
    logic [AW-1:0] w_off;
    assign w_off             = AW'(gi) - r_rd_ptr[AW-1:0];
    assign o_entry_valid[gi] = ({1'b0, w_off} < w_count);
    assign o_entry_rd[gi*REG_IDX_W +: REG_IDX_W] = r_mem[gi].rd;
  end

endmodule

// File: rtl/regs_writeback.sv
// Register-file write-port arbiter: ALU results win unless the buffered slow
// results have starved; one registered write per cycle, committed on the falling edge.
module regs_writeback
  import regs_writeback_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 aluValid,
  input  logic [4:0]           aluRd,
  input  logic [31:0]          aluData,
  input  logic                 memValid,
  output logic                 memReady,
  input  logic [4:0]           memRd,
  input  logic [31:0]          memData,
  output logic                 regsWriteEnable,
  output logic [4:0]           regWriteNum,
  output logic [31:0]          regWriteData,
  output logic [31:0]          pendingMask,
  output logic                 aluStall,
  output logic                 protocolError
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic                        w_full;
  logic                        w_empty;
  logic [REG_IDX_W-1:0]        w_head_rd;
  logic [XLEN-1:0]             w_head_data;
  logic [FIFO_DEPTH-1:0]       w_entry_valid;
  logic [FIFO_DEPTH*REG_IDX_W-1:0] w_entry_rd;
  logic                        w_mem_ready;
  logic                        w_push;
  logic                        w_pop;
  logic                        w_alu_take;
  logic                        w_waw;
  logic                        w_stall_drop;
  logic [NUM_REGS-1:0]         w_pending;
  logic [CW-1:0]               w_starve_inc;

  logic                        r_we;
  logic [REG_IDX_W-1:0]        r_wnum;
  logic [XLEN-1:0]             r_wdata;
  logic                        r_alu_stall;
  logic                        r_error;
  logic [CW-1:0]               r_starve_cnt;

  // No pass-through: a slot freed by this edge's pop is not offered until the next cycle.
  assign w_mem_ready = !w_full && !rst;
  assign w_push      = memValid && w_mem_ready && (memRd != '0);

  assign w_alu_take   = !r_alu_stall && aluValid && (aluRd != '0);
  assign w_pop        = !w_alu_take && !w_empty;
  assign w_waw        = w_alu_take && w_pending[aluRd];
  assign w_stall_drop = r_alu_stall && aluValid;
  assign w_starve_inc = r_starve_cnt + CW'(1);

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk           (clk),
    .rst           (rst),
    .i_push        (w_push),
    .i_push_rd     (memRd),
    .i_push_data   (memData),
    .i_pop         (w_pop),
    .o_head_rd     (w_head_rd),
    .o_head_data   (w_head_data),
    .o_full        (w_full),
    .o_empty       (w_empty),
    .o_entry_valid (w_entry_valid),
    .o_entry_rd    (w_entry_rd)
  );

  always_comb begin
    w_pending = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (w_entry_valid[i]) begin
        w_pending = w_pending | rd_onehot(w_entry_rd[i*REG_IDX_W +: REG_IDX_W]);
      end
    end
    w_pending[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_wnum  <= '0;
      r_wdata <= '0;
    end else if (w_alu_take) begin
      r_we    <= 1'b1;
      r_wnum  <= aluRd;
      r_wdata <= aluData;
    end else if (w_pop) begin
      r_we    <= 1'b1;
      r_wnum  <= w_head_rd;
      r_wdata <= w_head_data;
    end else begin
      r_we    <= 1'b0;
    end
  end

  // Starvation: count ALU wins over a waiting head; stall from the limit until the next pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= '0;
      r_alu_stall  <= 1'b0;
    end else if (w_empty || w_pop) begin
      r_starve_cnt <= '0;
      r_alu_stall  <= 1'b0;
    end else if (w_alu_take) begin
      r_starve_cnt <= w_starve_inc;
      if (w_starve_inc >= CW'(STARVE_LIMIT)) r_alu_stall <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        r_error <= 1'b0;
    else if (w_waw || w_stall_drop) r_error <= 1'b1;
  end

  assign memReady        = w_mem_ready;
  assign regsWriteEnable = r_we;
  assign regWriteNum     = r_wnum;
  assign regWriteData    = r_wdata;
  assign pendingMask     = w_pending;
  assign aluStall        = r_alu_stall;
  assign protocolError   = r_error;

endmodule

// File: doc/regs_writeback.md
# regs_writeback

Writeback arbiter that owns the single write port of the register file. It merges a single-cycle ALU result stream with a long-latency load/divide result stream. Slow results are buffered in a small FIFO, and one registered write per cycle is presented to the register file, which commits it on the following falling edge. The block also publishes a pending-destination mask that decode uses to stall on unwritten registers.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: slow-result buffer entries; power of two, at least 2.
- `STARVE_LIMIT`, default 8: consecutive cycles a FIFO head may lose arbitration before `aluStall` is raised.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `aluValid` in 1: ALU result present this cycle; no ready, always accepted.
- `aluRd` in 5: ALU destination register.
- `aluData` in 32: ALU result.
- `memValid` in 1: slow result offered.
- `memReady` out 1: slow result accepted when `memValid && memReady` at the rising edge.
- `memRd` in 5: slow-result destination register.
- `memData` in 32: slow result.
- `regsWriteEnable` out 1: registered write strobe to the register file.
- `regWriteNum` out 5: registered write index.
- `regWriteData` out 32: registered write data.
- `pendingMask` out 32: bit i is set while any FIFO entry targets xi; bit 0 is always 0.
- `aluStall` out 1: registered request for the ALU producer to withhold results.
- `protocolError` out 1: sticky error flag, cleared only by `rst`.

## Operation
- Source selection is made every rising edge and loaded into the output register:
  - `aluStall`=0 and `aluValid` with `aluRd`≠0: the ALU result is written.
  - Otherwise, FIFO non-empty: the FIFO head is popped and written.
  - Otherwise: `regsWriteEnable`=0, and `regWriteNum`/`regWriteData` hold their previous values.
- `aluStall`=1 gives the FIFO head absolute priority. An `aluValid` result in that cycle is dropped and sets `protocolError`.
- Writes to x0 are discarded at the input:
  - A slow result with `memRd`=0 is accepted (handshake completes) but not enqueued.
  - An ALU result with `aluRd`=0 is ignored and does not block the FIFO.
- `memReady` = !full, and is 0 while `rst` is asserted. There is no same-cycle pass-through when full: a pop at a full edge does not free a slot for that edge.
- There is no bypass. A slow result always passes through the FIFO, even when the FIFO is empty and the ALU is idle.
- FIFO order is strict.
- `pendingMask` is the OR of the one-hot destinations of all valid FIFO entries. It is combinational from the FIFO state.
- WAW check: an accepted ALU write whose `aluRd` bit is set in `pendingMask` sets `protocolError`. The write is still performed.
- Starvation counter:
  - Increments on each edge where the FIFO is non-empty and the ALU wins arbitration.
  - Clears on any pop and whenever the FIFO is empty.
  - Reaching `STARVE_LIMIT` sets `aluStall` at that edge.
  - `aluStall` clears on the edge of the next pop.
- Read/write pointers are log2(`FIFO_DEPTH`) bits wide with an extra wrap bit. Full and empty are derived from pointer equality plus the wrap bit.

## Timing
- ALU result presented in cycle N appears on the write outputs in cycle N+1 and commits at the falling edge of N+1.
- Slow result accepted at the end of cycle N:
  - is enqueued at that edge;
  - is earliest on the outputs in cycle N+2;
  - commits at the falling edge of N+2.
- A slow result's `pendingMask` bit rises in cycle N+1 and falls in the cycle its write is on the outputs. At that point the pending value is committed at that cycle's falling edge.
- Simultaneous push and pop, not full: both occur, and occupancy is unchanged.
- Pop that empties the FIFO: the starvation counter clears and `aluStall` deasserts at the same edge.
- Reset values, applied immediately on `rst` assertion, including mid-operation:
  - outputs: `regsWriteEnable`=0, `regWriteNum`=0, `regWriteData`=0, `aluStall`=0, `protocolError`=0, `memReady`=0;
  - internal state: FIFO empty (`pendingMask`=0), starvation counter 0;
  - in-flight FIFO contents are lost.

## Structure
- Shared package holds:
  - `REG_IDX_W`=5 and `XLEN`=32;
  - a writeback-entry struct {rd[4:0], data[31:0]}.
- One sub-module, `wb_fifo`: a parameterized synchronous FIFO providing push, pop, full, empty, head, and a per-entry valid/rd view for building `pendingMask`.
- Arbitration, the starvation counter and error logic live in the top level.

## Test plan
- ALU x5=0x11 in cycle 1 → cycle 2: `regsWriteEnable`=1, `regWriteNum`=5, `regWriteData`=0x11; register x5 reads 0x11 after the falling edge.
- Slow x7=0xAB accepted with the ALU idle → `pendingMask`[7]=1 for one cycle; write on the outputs 2 cycles after acceptance; mask then 0.
- Four slow results fill the FIFO (`FIFO_DEPTH`=4) → `memReady`=0; a fifth `memValid` is held off; order preserved on drain; `memReady`=1 after the first pop.
- Slow x3 queued while the ALU writes x9 every cycle → after 8 losses `aluStall`=1; the next edge pops x3; `aluStall`=0 the cycle after.
- Error triggers: ALU write to x3 while `pendingMask`[3]=1, or `aluValid` during `aluStall` → `protocolError`=1 and stays set until `rst`.
- Assert `rst` with 3 entries queued → immediately `pendingMask`=0 and `regsWriteEnable`=0; the queued entries never appear after release.
